// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and command-format helpers for the SPI slave.
package spi_pkg;
  typedef enum logic [2:0] {
    IDLE, GET_CMD, GOT_CMD, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_COMMIT, DONE
  } state_t;
  localparam logic RW_READ = 1'b1;
  function automatic int cmd_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/spi_slave_fsm_if.sv
// spi_slave_fsm_if: conditioned SPI pin events plus the synchronous memory port.
interface spi_slave_fsm_if #(parameter int ADDR_W = 7, parameter int DATA_W = 8);
  logic cs_cond;
  logic sclk_pos;
  logic sclk_neg;
  logic mosi_cond;
  logic miso;
  logic miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic xfer_done;
  modport slave (
    input cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
    output miso, miso_oe, mem_addr, mem_wdata, mem_we, xfer_done
  );
  modport master (
    output cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
    input miso, miso_oe, mem_addr, mem_wdata, mem_we, xfer_done
  );
endinterface

// File: rtl/spi_shiftreg.sv
// spi_shiftreg: parallel-load, serial-in shift register, MSB-first, load wins over shift.
module spi_shiftreg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[W-2:0], sin};
endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: SPI mode-0 slave, command byte then one read/write word.
// Define SPI_AUTOINC_EN for burst mode with auto-incrementing address.
module spi_slave_fsm import spi_pkg::*; #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst_n,
  spi_slave_fsm_if.slave bus
);
  localparam int CMD_W = cmd_w(ADDR_W);
  localparam int RX_W  = ADDR_W > DATA_W - 1 ? ADDR_W : DATA_W - 1;
  localparam int CNT_W = $clog2((CMD_W > DATA_W ? CMD_W : DATA_W) + 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic rw;
  logic [RX_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic pos, neg, tx_unused;
  assign pos = bus.sclk_pos;
  assign neg = bus.sclk_neg & ~bus.sclk_pos;
  assign tx_unused = ^tx_q[DATA_W-2:0];
  // rx holds the bits preceding the current one; the live MOSI bit completes the word
  spi_shiftreg #(.W(RX_W)) u_rx (
    .clk(clk), .rst_n(rst_n), .load(1'b0),
    .shift(pos && (state == GET_CMD || state == WRITE_RECV)),
    .sin(bus.mosi_cond), .din('0), .q(rx_q)
  );
  spi_shiftreg #(.W(DATA_W)) u_tx (
    .clk(clk), .rst_n(rst_n), .load(state == READ_LOAD),
    .shift(neg && state == READ_SEND),
    .sin(1'b0), .din(bus.mem_rdata), .q(tx_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rw            <= 1'b0;
      bus.miso      <= 1'b0;
      bus.miso_oe   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.xfer_done <= 1'b0;
    end else begin
      bus.mem_we    <= 1'b0;
      bus.xfer_done <= 1'b0;
      if (bus.cs_cond && state != WRITE_COMMIT) begin
        state       <= IDLE;
        bus.miso_oe <= 1'b0;
      end else case (state)
        IDLE: begin
          state <= GET_CMD;
          cnt   <= '0;
        end
        GET_CMD: if (pos) begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(CMD_W - 1)) begin
            state        <= GOT_CMD;
            bus.mem_addr <= rx_q[ADDR_W-1:0];
            rw           <= bus.mosi_cond;
          end
        end
        GOT_CMD: begin
          state <= rw == RW_READ ? READ_LOAD : WRITE_RECV;
          cnt   <= '0;
        end
        READ_LOAD: begin
          state       <= READ_SEND;
          bus.miso_oe <= 1'b1;
        end
        READ_SEND: begin
          if (neg) bus.miso <= tx_q[DATA_W-1];
          if (pos) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              bus.xfer_done <= 1'b1;
`ifdef SPI_AUTOINC_EN
              state        <= GOT_CMD;
              bus.mem_addr <= bus.mem_addr + 1'b1;
`else
              state       <= DONE;
              bus.miso_oe <= 1'b0;
`endif
            end
          end
        end
        WRITE_RECV: if (pos) begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state         <= WRITE_COMMIT;
            bus.mem_wdata <= {rx_q[DATA_W-2:0], bus.mosi_cond};
            bus.mem_we    <= 1'b1;
            bus.xfer_done <= 1'b1;
          end
        end
        WRITE_COMMIT: begin
`ifdef SPI_AUTOINC_EN
          state        <= WRITE_RECV;
          bus.mem_addr <= bus.mem_addr + 1'b1;
          cnt          <= '0;
`else
          state <= DONE;
`endif
        end
        DONE: bus.miso_oe <= 1'b0;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: directed bench driving conditioned SPI events against a small memory model.
module tb_spi_slave_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [6:0] waddr;
  logic [7:0] wdata;
  logic [6:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] mem [128];
  spi_slave_fsm_if bus ();
  spi_slave_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end
  always @(negedge clk) begin
    if (bus.mem_we) begin
      we_cnt++;
      waddr = bus.mem_addr;
      wdata = bus.mem_wdata;
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
    end
    if (bus.xfer_done) done_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bit_x(input logic m, output logic s);
    @(negedge clk) bus.mosi_cond = m;
    repeat (3) @(negedge clk);
    s = bus.miso;
    bus.sclk_pos = 1'b1;
    @(negedge clk) bus.sclk_pos = 1'b0;
    repeat (4) @(negedge clk);
    bus.sclk_neg = 1'b1;
    @(negedge clk) bus.sclk_neg = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(b[i], s);
      got[i] = s;
    end
  endtask
  task automatic cs_lo();
    @(negedge clk) bus.cs_cond = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic cs_hi();
    @(negedge clk) bus.cs_cond = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, d0;
    logic [7:0] g;
    logic s;
    logic [7:0] cmd;
    bus.cs_cond = 1'b1;
    bus.sclk_pos = 1'b0;
    bus.sclk_neg = 1'b0;
    bus.mosi_cond = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", bus.miso, 0);
    check("rst_miso_oe", bus.miso_oe, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_xfer_done", bus.xfer_done, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    w0 = we_cnt; d0 = done_cnt;
    cs_lo();
    send(8'h54, g);
    send(8'hA5, g);
    repeat (3) @(negedge clk);
    check("wr_we_pulses", we_cnt - w0, 1);
    check("wr_addr", waddr, 7'h2A);
    check("wr_data", wdata, 8'hA5);
    check("wr_done_pulses", done_cnt - d0, 1);
    cs_hi();
    w0 = we_cnt; d0 = done_cnt;
    cs_lo();
    send(8'h54, g);
    for (int i = 0; i < 3; i++) bit_x(1'b1, s);
    cs_hi();
    check("abort_no_we", we_cnt - w0, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_miso_oe", bus.miso_oe, 0);
    w0 = we_cnt; d0 = done_cnt;
    cs_lo();
    send(8'h54, g);
    send(8'h3C, g);
    repeat (3) @(negedge clk);
    check("rewr_we_pulses", we_cnt - w0, 1);
    check("rewr_addr", waddr, 7'h2A);
    check("rewr_data", wdata, 8'h3C);
    check("rewr_done_pulses", done_cnt - d0, 1);
    cs_hi();
    d0 = done_cnt;
    cmd = 8'h55;
    cs_lo();
    for (int i = 7; i >= 1; i--) bit_x(cmd[i], s);
    check("rd_oe_cmd_phase", bus.miso_oe, 0);
    bit_x(cmd[0], s);
    check("rd_oe_data_phase", bus.miso_oe, 1);
    send(8'h00, g);
    check("rd_miso_byte", g, 8'h3C);
    check("rd_done_pulses", done_cnt - d0, 1);
    check("rd_oe_after_word", bus.miso_oe, 0);
    cs_hi();
    cs_lo();
    send(8'h55, g);
    bit_x(1'b0, s);
    bit_x(1'b0, s);
    check("mid_rd_oe", bus.miso_oe, 1);
    check("mid_rd_miso", bus.miso, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_miso", bus.miso, 0);
    check("async_rst_oe", bus.miso_oe, 0);
    check("async_rst_we", bus.mem_we, 0);
    check("async_rst_done", bus.xfer_done, 0);
    check("async_rst_addr", bus.mem_addr, 0);
    check("async_rst_wdata", bus.mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cs_cond = 1'b1;
    repeat (3) @(negedge clk);
`ifdef SPI_AUTOINC_EN
    w0 = we_cnt; d0 = done_cnt;
    wa_q.delete();
    wd_q.delete();
    cs_lo();
    send(8'hFE, g);
    send(8'h11, g);
    send(8'h22, g);
    repeat (3) @(negedge clk);
    cs_hi();
    check("burst_we_pulses", we_cnt - w0, 2);
    check("burst_done_pulses", done_cnt - d0, 2);
    check("burst_addr0", wa_q[0], 7'h7F);
    check("burst_data0", wd_q[0], 8'h11);
    check("burst_addr1_wrap", wa_q[1], 7'h00);
    check("burst_data1", wd_q[1], 8'h22);
`else
    w0 = we_cnt; d0 = done_cnt;
    cs_lo();
    send(8'h55, g);
    for (int i = 0; i < 12; i++) bit_x(1'b0, s);
    check("extra_done_pulses", done_cnt - d0, 1);
    check("extra_oe_after", bus.miso_oe, 0);
    check("extra_no_we", we_cnt - w0, 0);
    cs_hi();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- SPI mode-0 slave transaction controller, directly downstream of the input conditioners on the CS, SCLK and MOSI pins.
- Consumes the conditioned CS level, the conditioned MOSI level, and the SCLK rising/falling edge pulses.
- Decodes a command byte (address + R/W), then reads or writes one data word through a simple synchronous memory port.
- Drives MISO with a tri-state enable to the pad.

Parameters:
- ADDR_W, 7, memory address width; command word is ADDR_W+1 bits.
- DATA_W, 8, data word width.

Ports:
- clk  in  1  system clock, same domain as the conditioners.
- rst_n  in  1  asynchronous reset, active low.
- cs_cond  in  1  conditioned chip select, active low.
- sclk_pos  in  1  one-clk pulse on conditioned SCLK rising edge.
- sclk_neg  in  1  one-clk pulse on conditioned SCLK falling edge.
- mosi_cond  in  1  conditioned MOSI level.
- miso  out  1  serial read data.
- miso_oe  out  1  MISO pad output enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe, one clk wide.
- mem_rdata  in  DATA_W  memory read data, valid one clk after mem_addr changes.
- xfer_done  out  1  one-clk pulse on completion of each read or write word.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE; miso, miso_oe, mem_we, xfer_done = 0; mem_addr, mem_wdata, shift reg, bit counter = 0.
- Assumption on inputs: SCLK half-period is at least 4 clk after conditioning. If sclk_pos and sclk_neg are both asserted in the same clk, sclk_neg is ignored.
- CS abort: cs_cond=1 in any state except WRITE_COMMIT forces state IDLE on the next clk, with miso_oe=0 and no write. WRITE_COMMIT always completes its write.
- IDLE: cs_cond=0 -> GET_CMD; counter=0.
- GET_CMD: on each sclk_pos, shift in mosi_cond MSB-first and increment the counter. On the (ADDR_W+1)-th sclk_pos -> GOT_CMD; mem_addr <= cmd[ADDR_W:1]; rw <= cmd[0] (1=read).
- GOT_CMD: one clk, waits out memory read latency. rw=1 -> READ_LOAD; rw=0 -> WRITE_RECV; counter=0 in both cases.
- READ_LOAD: one clk. tx <= mem_rdata; miso_oe <= 1. -> READ_SEND.
- READ_SEND:
  - On each sclk_neg: miso <= tx[DATA_W-1]; tx <= tx<<1.
  - On each sclk_pos: counter++.
  - On the DATA_W-th sclk_pos: pulse xfer_done -> DONE.
  - The first data bit is therefore driven on the SCLK fall that ends the command phase.
- WRITE_RECV: shift mosi_cond in on each sclk_pos. On the DATA_W-th sclk_pos: mem_wdata <= shift -> WRITE_COMMIT.
- WRITE_COMMIT: mem_we=1 for exactly this clk; pulse xfer_done -> DONE.
- DONE: miso_oe=0; further SCLK edges are ignored. cs_cond=1 -> IDLE.
- Output timing: all outputs are registered; miso holds its value between sclk_neg pulses.

Optional Feature:
- Macro: SPI_AUTOINC_EN (burst mode).
- When defined:
  - READ_SEND end -> GOT_CMD with mem_addr+1, then continues streaming while cs_cond=0.
  - WRITE_COMMIT -> WRITE_RECV with mem_addr+1 and counter=0.
  - Address wraps from 2^ADDR_W-1 to 0.
  - xfer_done pulses once per word.
- When undefined: exactly one word per CS assertion, as above.

Decomposition:
- Package spi_pkg: state enumeration (IDLE, GET_CMD, GOT_CMD, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_COMMIT, DONE), CMD_W=ADDR_W+1, constant RW_READ=1.
- Sub-module spi_shiftreg: parallel-load, serial-in/serial-out shift register with a shift-enable input. Two instances: command/write-data receive, and read-data transmit.

Test Plan:
- Write: CS low; command 0x54 (addr 0x2A, W); data 0xA5 -> single mem_we pulse, mem_addr=0x2A, mem_wdata=0xA5, xfer_done pulse.
- Read: command 0x55 (addr 0x2A, R); mem_rdata=0x3C -> miso shows 0,0,1,1,1,1,0,0 at successive sclk_pos; miso_oe=1 only in the data phase.
- Abort: CS high after 3 write-data bits -> no mem_we; IDLE within 1 clk; a following full write transaction succeeds normally.
- Reset: assert rst_n low mid-READ_SEND -> all outputs 0 immediately, without waiting for a clk edge.
- Extra edges: 20 SCLK cycles with CS low (single-word build) -> exactly one xfer_done; miso_oe=0 after the word.
- SPI_AUTOINC_EN: write burst at addr 0x7F with data 0x11, 0x22 -> writes to 0x7F then 0x00; two xfer_done pulses.
